// File: rtl/aes_ctr_stream_if.sv
// Handshake bundle for aes_ctr_stream: job request/result signals plus the
// request/response pair towards the external AES-256 block core.
interface aes_ctr_stream_if #(
    parameter int MAX_BLOCKS = 8
) ();
    localparam int NB_W = $clog2(MAX_BLOCKS + 1);

    // Job side
    logic                      start;
    logic [127:0]              iv;
    logic [NB_W-1:0]           num_blocks;
    logic [4:0]                last_bytes;
    logic [MAX_BLOCKS*128-1:0] data_in;
    logic                      busy;
    logic                      done;
    logic                      err;
    logic [MAX_BLOCKS*128-1:0] data_out;
    logic [127:0]              ctr_next;

    // AES core side
    logic                      core_start;
    logic [127:0]              core_block;
    logic                      core_done;
    logic [127:0]              core_keystream;

    // The stream engine itself
    modport slave (
        input  start, iv, num_blocks, last_bytes, data_in,
        input  core_done, core_keystream,
        output busy, done, err, data_out, ctr_next,
        output core_start, core_block
    );

    // The surrounding system: job issuer plus the AES core
    modport master (
        output start, iv, num_blocks, last_bytes, data_in,
        output core_done, core_keystream,
        input  busy, done, err, data_out, ctr_next,
        input  core_start, core_block
    );
endinterface

// File: rtl/aes_ctr_stream.sv
// AES counter-mode stream engine. Walks up to MAX_BLOCKS counter blocks
// through an external AES-256 core one at a time, XORs each keystream block
// with the latched input data and publishes the whole result on completion.
// Encryption and decryption are the same operation.
module aes_ctr_stream #(
    parameter int MAX_BLOCKS = 8,
    parameter int CTR_WIDTH  = 32
) (
    input  logic            clk,
    input  logic            rst,
    aes_ctr_stream_if.slave bus
);
    localparam int NB_W = $clog2(MAX_BLOCKS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [127:0]              r_ctr;
    logic [NB_W-1:0]           r_idx;
    logic [NB_W-1:0]           r_num;
    logic [4:0]                r_lb;
    logic                      r_done;
    logic                      r_err;
    logic [MAX_BLOCKS*128-1:0] r_data_out;
    logic [127:0]              r_ctr_next;

    logic                      w_nb_legal;
    logic                      w_accept;
    logic                      w_consume;
    logic [NB_W-1:0]           w_idx_inc;
    logic                      w_last_blk;
    logic [4:0]                w_lb_eff;
    logic [127:0]              w_keep_mask;
    logic [127:0]              w_ctr_inc;
    logic [MAX_BLOCKS*128-1:0] w_work_flat;

    // A job is only legal for 1..MAX_BLOCKS blocks
    assign w_nb_legal = (bus.num_blocks != '0) &&
                        (bus.num_blocks <= NB_W'(MAX_BLOCKS));
    assign w_accept   = (r_state == S_IDLE) && bus.start && w_nb_legal;
    // Keystream responses are only meaningful while waiting for one
    assign w_consume  = (r_state == S_WAIT) && bus.core_done;

    assign w_idx_inc  = r_idx + NB_W'(1);
    assign w_last_blk = (w_idx_inc == r_num);

    // A byte count of 0 or anything beyond 16 means a full final block
    assign w_lb_eff   = ((r_lb == 5'd0) || (r_lb > 5'd16)) ? 5'd16 : r_lb;

    // Byte keep-mask for the block being consumed; byte 0 is the MSB byte
    // and only the final block of a job is trimmed.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_mask
            assign w_keep_mask[127-8*gi -: 8] =
                (w_last_blk && (5'(gi) >= w_lb_eff)) ? 8'h00 : 8'hFF;
        end
    endgenerate

    // Only the low CTR_WIDTH bits count; they wrap without carrying upward
    generate
        if (CTR_WIDTH >= 128) begin : g_ctr_full
            assign w_ctr_inc = r_ctr + 128'd1;
        end else begin : g_ctr_part
            assign w_ctr_inc = {r_ctr[127:CTR_WIDTH],
                                r_ctr[CTR_WIDTH-1:0] + CTR_WIDTH'(1)};
        end
    endgenerate

    // One lane per block: latched input and its keystream-XORed result.
    // Lanes beyond the job length stay at the zero they were cleared to.
    generate
        for (gi = 0; gi < MAX_BLOCKS; gi++) begin : g_blk
            logic [127:0] r_din_blk;
            logic [127:0] r_work_blk;

            // Capture input on accept, fill the result when this lane's keystream arrives
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_din_blk  <= '0;
                    r_work_blk <= '0;
                end else if (w_accept) begin
                    r_din_blk  <= bus.data_in[128*gi +: 128];
                    r_work_blk <= '0;
                end else if (w_consume && (r_idx == NB_W'(gi))) begin
                    r_work_blk <= (r_din_blk ^ bus.core_keystream) & w_keep_mask;
                end
            end

            assign w_work_flat[128*gi +: 128] = r_work_blk;
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.core_done) begin
                    w_state_next = w_last_blk ? S_FIN : S_REQ;
                end
            end
            S_FIN: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Job context: counter, block index and length parameters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctr <= '0;
            r_idx <= '0;
            r_num <= '0;
            r_lb  <= '0;
        end else if (w_accept) begin
            r_ctr <= bus.iv;
            r_idx <= '0;
            r_num <= bus.num_blocks;
            r_lb  <= bus.last_bytes;
        end else if (w_consume) begin
            r_ctr <= w_ctr_inc;
            r_idx <= w_idx_inc;
        end
    end

    // Result publication in FIN plus the done/err status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_data_out <= '0;
            r_ctr_next <= '0;
        end else begin
            r_done <= (r_state == S_FIN);
            r_err  <= (r_state == S_IDLE) && bus.start && !w_nb_legal;
            if (r_state == S_FIN) begin
                r_data_out <= w_work_flat;
                r_ctr_next <= r_ctr;
            end
        end
    end

    // The counter register doubles as the core request block: it only
    // advances on core_done, so it is stable for the whole request.
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.data_out   = r_data_out;
    assign bus.ctr_next   = r_ctr_next;
    assign bus.core_start = (r_state == S_REQ);
    assign bus.core_block = r_ctr;

endmodule

// File: tb/tb_aes_ctr_stream.sv
// Directed bench for aes_ctr_stream with a latency-configurable AES core model.
module tb_aes_ctr_stream;
    localparam int MAXB = 8;
    localparam int NB_W = $clog2(MAXB + 1);

    localparam logic [255:0] FIPS_KEY =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] FIPS_IV = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] PT3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] PT4 = 128'hf69f2445df4f9b17ad2b417be66c3710;
    localparam logic [127:0] CT1 = 128'h601ec313775789a5b7a7f504bbf3d228;
    localparam logic [127:0] CT2 = 128'hf443e3ca4d62b59aca84e990cacaf5c5;
    localparam logic [127:0] CT3 = 128'h2b0930daa23de94ce87017ba2d84988d;
    localparam logic [127:0] CT4 = 128'hdfc9c58db67aada613c2dd08457941a6;
    localparam logic [127:0] KS1 = 128'h0bdf7df1591716335e9a8b15c860c502;
    localparam logic [127:0] KS2 = 128'h5a6e699d536119065433863c8f657b94;
    localparam logic [127:0] KS3 = 128'h1bc12c9c01610d5d0d8bd6a3378eca62;
    localparam logic [127:0] KS4 = 128'h2956e1c8693536b1bee99c73a31576b6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_ctr_stream_if #(.MAX_BLOCKS(MAXB)) bus ();

    aes_ctr_stream #(.MAX_BLOCKS(MAXB), .CTR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int done_cyc = 0;
    int cd_cyc   = 0;
    int core_lat = 14;
    logic [255:0] cur_key = FIPS_KEY;
    logic [127:0] blk_log[$];

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [MAXB*128-1:0] exp);
        for (int b = 0; b < MAXB; b++)
            check($sformatf("%s_blk%0d", tag, b), bus.data_out[128*b +: 128], exp[128*b +: 128]);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Keystream of the core model: the published vectors for the FIPS key,
    // otherwise an arbitrary deterministic mix of key and counter block.
    function automatic logic [127:0] ks_fn(input logic [255:0] key, input logic [127:0] blk);
        logic [127:0] a;
        if (key == FIPS_KEY) begin
            case (blk)
                128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff: return KS1;
                128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00: return KS2;
                128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01: return KS3;
                128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff02: return KS4;
                default: ;
            endcase
        end
        a = blk ^ key[255:128];
        a = {a[90:0], a[127:91]} ^ key[127:0];
        a = a ^ {4{a[31:0] * 32'h9E3779B1}};
        return a;
    endfunction

    function automatic logic [MAXB*128-1:0] fips_din();
        logic [MAXB*128-1:0] d;
        d = {MAXB{128'hA5A55A5AC3C33C3C0F0FF0F012345678}};
        d[127:0]   = PT1;
        d[255:128] = PT2;
        d[383:256] = PT3;
        d[511:384] = PT4;
        return d;
    endfunction

    function automatic logic [MAXB*128-1:0] mask_exp(input logic [MAXB*128-1:0] d,
                                                     input int nb, input int lb);
        logic [MAXB*128-1:0] r;
        int eff;
        r = '0;
        eff = (lb == 0 || lb > 16) ? 16 : lb;
        for (int b = 0; b < nb; b++) r[128*b +: 128] = d[128*b +: 128];
        for (int k = eff; k < 16; k++) r[128*(nb-1) + 127 - 8*k -: 8] = 8'h00;
        return r;
    endfunction

    // Cycle counter and event monitor, sampled on the falling edge
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc_cnt;
        end
        if (bus.err === 1'b1) err_cnt++;
        if (bus.core_done === 1'b1) cd_cyc = cyc_cnt;
    end

    // AES core model: answers each core_start after core_lat cycles
    initial begin : core_model
        logic [127:0] blk;
        int wcnt;
        bit pending;
        bus.core_done = 1'b0;
        bus.core_keystream = '0;
        blk = '0;
        wcnt = 0;
        pending = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.core_done = 1'b0;
            if (pending) begin
                if (wcnt <= 0) begin
                    if (bus.busy === 1'b1) check("core_block_hold", bus.core_block, blk);
                    bus.core_keystream = ks_fn(cur_key, blk);
                    bus.core_done = 1'b1;
                    pending = 0;
                end else begin
                    wcnt--;
                end
            end else if (bus.core_start === 1'b1) begin
                blk = bus.core_block;
                blk_log.push_back(blk);
                pending = 1;
                wcnt = core_lat - 1;
            end
        end
    end

    task automatic run_job(input string name, input logic [127:0] iv, input int nb, input int lb,
                           input logic [MAXB*128-1:0] din, input bit poke_busy, input bit poke_fin);
        int cyc;
        int n0;
        bit fin_next;
        blk_log.delete();
        n0 = done_cnt;
        cyc = 0;
        fin_next = 0;
        bus.iv = iv;
        bus.num_blocks = NB_W'(nb);
        bus.last_bytes = 5'(lb);
        bus.data_in = din;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && cyc < 3000) begin
            bus.start = 1'b0;
            if (fin_next) begin
                check({name, "_fin_busy"}, bus.busy, 1);
                bus.start = 1'b1;
                bus.iv = ~iv;
                bus.num_blocks = NB_W'(1);
                fin_next = 0;
            end else if (poke_busy && cyc == 3) begin
                bus.start = 1'b1;
                bus.num_blocks = '0;
            end
            if (poke_fin && bus.core_done === 1'b1 && blk_log.size() == nb) fin_next = 1;
            step();
            cyc++;
        end
        bus.start = 1'b0;
        check({name, "_done"}, bus.done, 1);
        @(negedge clk);
        #1;
        check({name, "_latency"}, done_cyc - cd_cyc, 2);
        step();
        check({name, "_pulse"}, bus.done, 0);
        check({name, "_once"}, done_cnt - n0, 1);
        $display("job %s nb=%0d lb=%0d cycles=%0d", name, nb, lb, cyc);
    endtask

    initial begin : watchdog
        #500000;
        n_fail++;
        $display("FAIL watchdog act=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "bench timed out");
    end

    initial begin : main
        logic [MAXB*128-1:0] exp;
        logic [127:0] iv_w;
        int n0;
        int cyc;

        bus.start = 1'b0;
        bus.iv = '0;
        bus.num_blocks = '0;
        bus.last_bytes = '0;
        bus.data_in = '0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_core_start", bus.core_start, 0);
        check("rst_core_block", bus.core_block, 0);
        check("rst_ctr_next", bus.ctr_next, 0);
        check_out("rst", '0);

        // Published CTR-AES256 vectors, core latency 14, illegal start while busy
        cur_key = FIPS_KEY;
        core_lat = 14;
        run_job("fips", FIPS_IV, 4, 16, fips_din(), 1, 0);
        exp = '0;
        exp[127:0] = CT1;
        exp[255:128] = CT2;
        exp[383:256] = CT3;
        exp[511:384] = CT4;
        check_out("fips", exp);
        check("fips_ctr_next", bus.ctr_next, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff03);
        check("fips_nreq", blk_log.size(), 4);

        // Counter wrap in the low 32 bits without carry
        cur_key = 256'h1;
        core_lat = 3;
        iv_w = {96'h0123456789abcdef01234567, 32'hFFFFFFFE};
        run_job("wrap", iv_w, 3, 16, fips_din(), 0, 0);
        check("wrap_nreq", blk_log.size(), 3);
        if (blk_log.size() >= 3) begin
            check("wrap_blk0", blk_log[0], {96'h0123456789abcdef01234567, 32'hFFFFFFFE});
            check("wrap_blk1", blk_log[1], {96'h0123456789abcdef01234567, 32'hFFFFFFFF});
            check("wrap_blk2", blk_log[2], {96'h0123456789abcdef01234567, 32'h00000000});
        end
        check("wrap_ctr_next", bus.ctr_next, {96'h0123456789abcdef01234567, 32'h00000001});
        exp = '0;
        exp[127:0]   = PT1 ^ ks_fn(256'h1, {96'h0123456789abcdef01234567, 32'hFFFFFFFE});
        exp[255:128] = PT2 ^ ks_fn(256'h1, {96'h0123456789abcdef01234567, 32'hFFFFFFFF});
        exp[383:256] = PT3 ^ ks_fn(256'h1, {96'h0123456789abcdef01234567, 32'h00000000});
        check_out("wrap", exp);

        // Final-block byte mask, tail blocks zero, start during FIN ignored
        cur_key = FIPS_KEY;
        run_job("mask", FIPS_IV, 2, 5, fips_din(), 0, 1);
        exp = '0;
        exp[127:0]   = CT1;
        exp[255:128] = 128'hf443e3ca4d0000000000000000000000;
        check_out("mask", exp);
        repeat (3) step();
        check("fin_start_busy", bus.busy, 0);
        check("fin_start_nreq", blk_log.size(), 2);

        // last_bytes of 0 and of 20 both mean a full block
        run_job("lb0", FIPS_IV, 1, 0, fips_din(), 0, 0);
        exp = '0;
        exp[127:0] = CT1;
        check_out("lb0", exp);
        run_job("lb20", FIPS_IV, 1, 20, fips_din(), 0, 0);
        check_out("lb20", exp);
        check("lb20_ctr_next", bus.ctr_next, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00);

        // Illegal block counts 0 and MAX_BLOCKS+1
        for (int t = 0; t < 2; t++) begin
            bus.num_blocks = (t == 0) ? NB_W'(0) : NB_W'(MAXB + 1);
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            check($sformatf("err%0d_pulse", t), bus.err, 1);
            check($sformatf("err%0d_busy", t), bus.busy, 0);
            step();
            check($sformatf("err%0d_clear", t), bus.err, 0);
            check($sformatf("err%0d_busy2", t), bus.busy, 0);
            check($sformatf("err%0d_dout", t), bus.data_out[127:0], CT1);
            $display("job err nb=%0d", bus.num_blocks);
        end

        // Reset during the wait for block 2, then a late core_done from the core
        blk_log.delete();
        n0 = done_cnt;
        core_lat = 14;
        bus.iv = FIPS_IV;
        bus.num_blocks = NB_W'(4);
        bus.last_bytes = 5'd16;
        bus.data_in = fips_din();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 0;
        while (blk_log.size() < 2 && cyc < 500) begin
            step();
            cyc++;
        end
        check("abort_reach", blk_log.size(), 2);
        repeat (3) step();
        check("abort_busy_pre", bus.busy, 1);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (20) step();
        check("abort_busy", bus.busy, 0);
        check("abort_no_done", done_cnt - n0, 0);
        check("abort_ctr_next", bus.ctr_next, 0);
        check("abort_core_block", bus.core_block, 0);
        check("abort_core_start", bus.core_start, 0);
        check_out("abort", '0);
        $display("job abort cycles=%0d", cyc);

        run_job("after_abort", FIPS_IV, 4, 16, fips_din(), 0, 0);
        exp = '0;
        exp[127:0] = CT1;
        exp[255:128] = CT2;
        exp[383:256] = CT3;
        exp[511:384] = CT4;
        check_out("after_abort", exp);

        // Encrypt then decrypt with random key, iv and length
        for (int t = 0; t < 3; t++) begin
            logic [MAXB*128-1:0] pt;
            logic [MAXB*128-1:0] ct;
            logic [127:0] iv_r;
            int nb;
            int lb;
            nb = (t == 0) ? 1 : (t == 1) ? MAXB : int'($urandom_range(2, MAXB - 1));
            lb = (t == 0) ? 0 : int'($urandom_range(1, 20));
            for (int w = 0; w < MAXB * 4; w++) pt[32*w +: 32] = $urandom;
            for (int w = 0; w < 4; w++) iv_r[32*w +: 32] = $urandom;
            for (int w = 0; w < 8; w++) cur_key[32*w +: 32] = $urandom;
            core_lat = 1 + t;
            run_job($sformatf("rt%0d_enc", t), iv_r, nb, lb, pt, 0, 0);
            ct = bus.data_out;
            run_job($sformatf("rt%0d_dec", t), iv_r, nb, lb, ct, 0, 0);
            check_out($sformatf("rt%0d", t), mask_exp(pt, nb, lb));
        end

        check("err_total", err_cnt, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
